// File: rtl/fill_capture_if.sv
// Output event-word stream between fill_capture and its consumer.
// Handshake: a word transfers on every clock edge where outValid && outReady;
// while outValid is high and outReady is low, outData and outValid stay stable.
`timescale 1ns/1ps
interface fill_capture_if;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;

    modport master (output outData, output outValid, input outReady);
    modport slave  (input outData, input outValid, output outReady);
endinterface

// File: rtl/fill_capture.sv
// Fill capture: on each fill from the trigger manager, emit a header word,
// then the ADC samples that fall inside the fill window (through a small
// first-word-fall-through skid FIFO), then a trailer word carrying the final
// sample count and an overflow flag. Samples that arrive while the FIFO is
// full are counted but dropped.
`timescale 1ns/1ps
module fill_capture #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [7:0]    fillNum,
    input  logic [15:0]   fillLength,
    input  logic [11:0]   adcData,
    input  logic          adcValid,
    fill_capture_if.master out_bus,
    output logic          done,
    output logic          busy,
    output logic          overflow,
    output logic [2:0]    o_dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        COLLECT = 3'd2,
        TRAILER = 3'd3,
        WAITLOW = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_fill_num;
    logic [15:0]   r_fill_len;
    logic [15:0]   r_count;
    logic          r_overflow;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic          w_empty;
    logic          w_full;
    logic          w_window;
    logic          w_sample;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_start;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_window = ((r_state == HEADER) || (r_state == COLLECT)) &&
                      (r_count < r_fill_len);
    assign w_sample = w_window && adcValid;
    assign w_pop    = (r_state == COLLECT) && !w_empty && out_bus.outReady;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push   = w_sample && (!w_full || w_pop);
    assign w_drop   = w_sample && w_full && !w_pop;
    assign w_start  = (r_state == IDLE) && go;

    assign busy        = (r_state != IDLE);
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and per-state output word selection.
    always_comb begin
        w_next           = r_state;
        out_bus.outValid = 1'b0;
        out_bus.outData  = 32'd0;
        done             = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) w_next = HEADER;
            end
            HEADER: begin
                out_bus.outValid = 1'b1;
                out_bus.outData  = {4'hA, 4'h0, r_fill_num, r_fill_len};
                if (out_bus.outReady) w_next = COLLECT;
            end
            COLLECT: begin
                out_bus.outValid = !w_empty;
                out_bus.outData  = w_empty ? 32'd0 : r_mem[r_rd_ptr[AW-1:0]];
                if ((r_count == r_fill_len) && w_empty) w_next = TRAILER;
            end
            TRAILER: begin
                out_bus.outValid = 1'b1;
                out_bus.outData  = {4'hE, 3'b000, r_overflow, r_fill_num, r_count};
                if (out_bus.outReady) begin
                    done   = 1'b1;
                    w_next = WAITLOW;
                end
            end
            WAITLOW: begin
                // Stale go from the finished fill must not restart capture.
                if (!go) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Fill parameters, sample counter, overflow flag and FIFO pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill_num <= 8'd0;
            r_fill_len <= 16'd0;
            r_count    <= 16'd0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_start) begin
                r_fill_num <= fillNum;
                r_fill_len <= fillLength;
                r_count    <= 16'd0;
                r_overflow <= 1'b0;
            end else if (w_sample) begin
                r_count <= r_count + 16'd1;
            end
            if (w_drop) r_overflow <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage; sample index is the count before this sample is added.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {4'h1, r_count, adcData};
    end

endmodule

// File: tb/tb_fill_capture.sv
// Directed bench for fill_capture: header/sample/trailer sequences with
// hand-computed event words, overflow, stall, stale-go and reset-abort cases.
`timescale 1ns/1ps
module tb_fill_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic [7:0]  fillNum = 8'd0;
    logic [15:0] fillLength = 16'd0;
    logic [11:0] adcData = 12'd0;
    logic        adcValid = 1'b0;
    logic        done;
    logic        busy;
    logic        overflow;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_base = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;

    fill_capture_if bus();

    fill_capture #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .fillNum    (fillNum),
        .fillLength (fillLength),
        .adcData    (adcData),
        .adcValid   (adcValid),
        .out_bus    (bus.master),
        .done       (done),
        .busy       (busy),
        .overflow   (overflow),
        .o_dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: collect accepted words, count done pulses, check stall hold.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("hold_valid", {31'd0, bus.outValid}, 32'd1);
            check("hold_data", bus.outData, prev_data);
        end
        prev_stall = bus.outValid && !bus.outReady;
        prev_data  = bus.outData;
        if (bus.outValid && bus.outReady) got_q.push_back(bus.outData);
        if (done) begin
            done_cnt++;
            check("done_on_trailer",
                  {31'd0, bus.outValid && bus.outReady && (bus.outData[31:28] == 4'hE)}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [7:0] num, input logic [15:0] len);
        fillNum    = num;
        fillLength = len;
        go         = 1'b1;
        done_base  = done_cnt;
        tick();
    endtask

    task automatic stream_adc(input int n, input bit tog);
        for (int j = 0; j < n; j++) begin
            adcValid = 1'b1;
            adcData  = 12'h100 + 12'(j);
            if (tog) bus.outReady = ~bus.outReady;
            tick();
        end
        adcValid = 1'b0;
        adcData  = 12'd0;
    endtask

    task automatic wait_done(input int budget, input bit tog);
        int i = 0;
        while (done_cnt == done_base && i < budget) begin
            if (tog) bus.outReady = ~bus.outReady;
            tick();
            i++;
        end
        check("done_seen", 32'(done_cnt - done_base), 32'd1);
        bus.outReady = 1'b1;
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic end_fill();
        go = 1'b0;
        tick();
        tick();
    endtask

    // Watchdog.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.outReady = 1'b0;
        repeat (3) tick();
        // Reset state.
        check("rst_valid", {31'd0, bus.outValid}, 32'd0);
        check("rst_data", bus.outData, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic fill of 3 samples, consumer always ready.
        bus.outReady = 1'b1;
        start_fill(8'h05, 16'd3);
        check("t1_busy", {31'd0, busy}, 32'd1);
        stream_adc(3, 1'b0);
        wait_done(50, 1'b0);
        tick();
        tick();
        check("t1_single_done", 32'(done_cnt - done_base), 32'd1);
        exp_q = '{32'hA005_0003, 32'h1000_0100, 32'h1000_1101, 32'h1000_2102, 32'hE005_0003};
        check_words("t1");
        check("t1_ovf", {31'd0, overflow}, 32'd0);
        go = 1'b0;
        tick();
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        tick();

        // Zero-length fill: samples are outside the window.
        start_fill(8'h07, 16'd0);
        stream_adc(3, 1'b0);
        wait_done(50, 1'b0);
        exp_q = '{32'hA007_0000, 32'hE007_0000};
        check_words("t2");
        end_fill();

        // Consumer stalled through the window: FIFO fills, rest dropped.
        start_fill(8'h12, 16'd8);
        bus.outReady = 1'b0;
        stream_adc(8, 1'b0);
        tick();
        tick();
        check("t3_ovf_mid", {31'd0, overflow}, 32'd1);
        bus.outReady = 1'b1;
        wait_done(50, 1'b0);
        exp_q = '{32'hA012_0008, 32'h1000_0100, 32'h1000_1101, 32'h1000_2102,
                  32'h1000_3103, 32'hE112_0008};
        check_words("t3");
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        end_fill();

        // Consumer toggling ready every cycle.
        start_fill(8'h21, 16'd5);
        stream_adc(5, 1'b1);
        wait_done(60, 1'b1);
        exp_q = '{32'hA021_0005, 32'h1000_0100, 32'h1000_1101, 32'h1000_2102,
                  32'h1000_3103, 32'h1000_4104, 32'hE021_0005};
        check_words("t4");
        check("t4_ovf", {31'd0, overflow}, 32'd0);
        end_fill();

        // go held high after done: no re-trigger until go drops.
        start_fill(8'h33, 16'd1);
        stream_adc(1, 1'b0);
        wait_done(50, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t5_busy_%0d", k), {31'd0, busy}, 32'd1);
            check($sformatf("t5_state_%0d", k), {29'd0, dbg_state}, 32'd4);
        end
        exp_q = '{32'hA033_0001, 32'h1000_0100, 32'hE033_0001};
        check_words("t5");
        go = 1'b0;
        tick();
        check("t5_idle", {31'd0, busy}, 32'd0);
        start_fill(8'h34, 16'd0);
        wait_done(50, 1'b0);
        exp_q = '{32'hA034_0000, 32'hE034_0000};
        check_words("t5b");
        end_fill();

        // Reset in the middle of collection aborts the fill.
        start_fill(8'h40, 16'd8);
        stream_adc(3, 1'b0);
        check("t6_collect", {29'd0, dbg_state}, 32'd2);
        reset = 1'b0;
        go = 1'b0;
        #1;
        check("t6_valid", {31'd0, bus.outValid}, 32'd0);
        check("t6_data", bus.outData, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ovf", {31'd0, overflow}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t6_no_done", 32'(done_cnt - done_base), 32'd0);
        check("t6_wait_idle", {31'd0, busy}, 32'd0);
        got_q.delete();
        start_fill(8'h44, 16'd2);
        stream_adc(2, 1'b0);
        wait_done(50, 1'b0);
        exp_q = '{32'hA044_0002, 32'h1000_0100, 32'h1000_1101, 32'hE044_0002};
        check_words("t6");
        end_fill();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fill_capture.md
FILL_CAPTURE -- requirements
Module: fill_capture

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, sample skid-buffer depth (power of two, >=2).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-004 go  input  1  level from trigger manager; high while a fill is in progress.
REQ-005 fillNum  input  8  fill number; valid whenever go is high.
REQ-006 fillLength  input  16  samples per fill; sampled with fillNum at fill start.
REQ-007 adcData  input  12  ADC sample.
REQ-008 adcValid  input  1  adcData valid this cycle; no backpressure to ADC.
REQ-009 outData  output  32  event word.
REQ-010 outValid  output  1  outData valid.
REQ-011 outReady  input  1  consumer accepts word when outValid&outReady.
REQ-012 done  output  1  one-cycle pulse: fill complete; drives trigger manager done.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overflow  output  1  sticky per fill: at least one sample dropped.

Function
REQ-015 States: IDLE, HEADER, COLLECT, TRAILER, WAITLOW.
REQ-016 IDLE: on go=1, latch fillNum and fillLength, clear sample count and overflow, go to HEADER next cycle.
REQ-017 HEADER: outValid=1, outData={4'hA,4'h0,fillNum_latched,fillLength_latched}; on accept go to COLLECT.
REQ-018 Collection window open in HEADER and COLLECT while count < fillLength_latched; each adcValid increments count (16-bit, no wrap beyond fillLength_latched).
REQ-019 Window sample written to FIFO as {4'h1,count[15:0],adcData}, count taken before increment (first sample idx 0).
REQ-020 Window sample arriving with FIFO full is dropped, still counted, overflow set; samples outside window ignored.
REQ-021 Simultaneous FIFO write and read when full: read frees slot, write accepted, no overflow.
REQ-022 COLLECT: outValid = FIFO not empty, outData = FIFO head, pop on accept; FIFO is first-word-fall-through.
REQ-023 COLLECT -> TRAILER when count == fillLength_latched and FIFO empty.
REQ-024 TRAILER: outValid=1, outData={4'hE,3'b000,overflow,fillNum_latched,count}; on accept pulse done for that one cycle and go to WAITLOW.
REQ-025 WAITLOW: outValid=0; go to IDLE on first cycle go=0; blocks re-trigger on stale go.
REQ-026 fillLength=0: HEADER then TRAILER with count 0; no sample words.
REQ-027 outData and outValid hold stable while outValid=1 and outReady=0.
REQ-028 go falling before TRAILER accepted is ignored; fill completes normally.
REQ-029 Latency: HEADER valid one cycle after go first seen in IDLE; a sample written in cycle n appears on outData no earlier than n+1.

Reset
REQ-030 On reset low: state IDLE, FIFO empty, count 0, overflow 0, outValid 0, done 0, busy 0, outData 0.
REQ-031 Reset mid-fill aborts without done pulse; after release the block waits in IDLE for go=1.

Verification
REQ-032 fillNum=8'h05, fillLength=3, outReady=1, adcValid every cycle -> A005_0003, 1000_0xxx, 1000_1xxx, 1000_2xxx, E005_0003, done one cycle, busy low after go low.
REQ-033 fillLength=0, fillNum=8'h07 -> header A007_0000 then trailer E007_0000, done pulse, no sample words.
REQ-034 FIFO_DEPTH=4, fillLength=8, outReady=0 for 10 cycles during window -> 4 samples (idx 0-3) output, trailer E1nn_0008 with overflow=1.
REQ-035 outReady toggled every cycle, fillLength=5 -> all 5 samples in index order, words held stable while stalled, no overflow.
REQ-036 go held high 3 cycles after done -> stays in WAITLOW, no second header until go low then high.
REQ-037 reset asserted mid-COLLECT -> outputs zero immediately, no done; next go starts clean fill with count 0.
